// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The arbiter takes the slave side; requesters drive req through master.
interface rr_grant_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             timeout;

  modport master (
    output req,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req,
    output gnt, gnt_id, busy, timeout
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: registered one-hot grants, one idle gap between
// tenures, and a bounded hold time with a forced-release pulse.
module rr_grant_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic i_clk,
  input  logic i_rstn,
  rr_grant_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             to_q, to_d;

  logic             found;
  logic [N_REQ-1:0] win_oh;
  logic [ID_W-1:0]  win_id;

  function automatic int wrap_idx(int base, int off);
    int j;
    j = base + off;
    if (j >= N_REQ) j = j - N_REQ;
    if (j >= N_REQ) j = j - N_REQ;
    return j;
  endfunction

  // Scan upward from the slot after the last owner, so it ranks lowest.
  always_comb begin
    found  = 1'b0;
    win_oh = '0;
    win_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req[wrap_idx(int'(last_q) + 1, i)]) begin
        found = 1'b1;
        win_oh[wrap_idx(int'(last_q) + 1, i)] = 1'b1;
        win_id = ID_W'(wrap_idx(int'(last_q) + 1, i));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    id_d    = id_q;
    gnt_d   = gnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE, RELEASE: begin
        gnt_d = '0;
        if (found) begin
          state_d = GRANT;
          gnt_d   = win_oh;
          id_d    = win_id;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!bus.req[id_q]) begin
          state_d = RELEASE;
          gnt_d   = '0;
          last_d  = id_q;
          cnt_d   = '0;
        end else if (HOLD_MAX != 0 &&
                     cnt_q == CNT_W'(HOLD_MAX)) begin
          state_d = RELEASE;
          gnt_d   = '0;
          last_d  = id_q;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      gnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.busy    = |gnt_q;
  assign bus.timeout = to_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: reset, single grant, rotation,
// timeout, wrap fairness and asynchronous reset mid-grant.
module tb_rr_grant_arbiter;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  rr_grant_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

  rr_grant_arbiter #(
    .N_REQ(4), .ID_W(2), .HOLD_MAX(16), .CNT_W(5)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    bus.req = 4'b0000;
    #2;
    checks++;
    if ({bus.gnt, bus.gnt_id, bus.busy, bus.timeout} !== 8'h00) begin
      errors++;
      $display("FAIL reset_async got gnt=%b id=%0d busy=%b to=%b want all 0",
               bus.gnt, bus.gnt_id, bus.busy, bus.timeout);
    end
    #2;
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({bus.gnt, bus.busy, bus.timeout} !== 6'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got gnt=%b busy=%b to=%b want 0",
                 c, bus.gnt, bus.busy, bus.timeout);
      end
    end
  endtask

  task automatic test_single();
    bus.req = 4'b0100;
    tick();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got gnt=%b id=%0d busy=%b want 0100 2 1",
               bus.gnt, bus.gnt_id, bus.busy);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b0100) begin
        errors++;
        $display("FAIL single_hold cyc%0d got gnt=%b want 0100", c, bus.gnt);
      end
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_drop got gnt=%b busy=%b want 0000 0",
               bus.gnt, bus.busy);
    end
    tick();
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.gnt_id !== 2'd2) begin
      errors++;
      $display("FAIL single_idle got gnt=%b id=%0d want 0000 2",
               bus.gnt, bus.gnt_id);
    end
  endtask

  task automatic test_rotation();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp;
    do_reset();
    bus.req = 4'b1111;
    tick();
    for (int t = 0; t < 5; t++) begin
      exp = 4'b0001 << order[t];
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (bus.gnt !== exp || bus.gnt_id !== 2'(order[t])) begin
          errors++;
          $display("FAIL rot_t%0d_c%0d got gnt=%b id=%0d want %b %0d",
                   t, c, bus.gnt, bus.gnt_id, exp, order[t]);
        end
        if (c < 2) tick();
      end
      bus.req[order[t]] = 1'b0;
      tick();
      checks++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rot_gap%0d got gnt=%b busy=%b want 0000 0",
                 t, bus.gnt, bus.busy);
      end
      tick();
      bus.req[order[t]] = 1'b1;
    end
    bus.req = 4'b0000;
    tick();
    tick();
    tick();
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL rot_end got gnt=%b want 0000", bus.gnt);
    end
  endtask

  task automatic test_timeout();
    bus.req = 4'b0001;
    tick();
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (bus.gnt !== 4'b0001 || bus.timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_hold c%0d got gnt=%b to=%b want 0001 0",
                 c, bus.gnt, bus.timeout);
      end
      if (c < 16) tick();
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse got gnt=%b to=%b busy=%b want 0000 1 0",
               bus.gnt, bus.timeout, bus.busy);
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_regrant got gnt=%b to=%b want 0001 0",
               bus.gnt, bus.timeout);
    end
    // A competitor arriving mid-tenure must wait, then beat the timed-out owner.
    bus.req = 4'b0101;
    for (int c = 2; c <= 16; c++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b0001) begin
        errors++;
        $display("FAIL to_nopreempt c%0d got gnt=%b want 0001", c, bus.gnt);
      end
    end
    tick();
    checks++;
    if (bus.timeout !== 1'b1 || bus.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL to_pulse2 got gnt=%b to=%b want 0000 1",
               bus.gnt, bus.timeout);
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2) begin
      errors++;
      $display("FAIL to_fair got gnt=%b id=%0d want 0100 2",
               bus.gnt, bus.gnt_id);
    end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_drop_at_limit();
    bus.req = 4'b0010;
    tick();
    for (int c = 1; c < 16; c++) tick();
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL lim_hold got gnt=%b want 0010", bus.gnt);
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL lim_drop got gnt=%b to=%b want 0000 0",
               bus.gnt, bus.timeout);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 4'b1000;
    tick();
    checks++;
    if (bus.gnt !== 4'b1000 || bus.gnt_id !== 2'd3) begin
      errors++;
      $display("FAIL wrap_own3 got gnt=%b id=%0d want 1000 3",
               bus.gnt, bus.gnt_id);
    end
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b1001;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL wrap_after3 got gnt=%b id=%0d want 0001 0",
               bus.gnt, bus.gnt_id);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    bus.req = 4'b0010;
    tick();
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_own1 got gnt=%b want 0010", bus.gnt);
    end
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0011;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL wrap_after1 got gnt=%b id=%0d want 0001 0",
               bus.gnt, bus.gnt_id);
    end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b0010;
    tick();
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL ar_pre got gnt=%b want 0010", bus.gnt);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.gnt_id, bus.busy, bus.timeout} !== 8'h00) begin
      errors++;
      $display("FAIL ar_clear got gnt=%b id=%0d busy=%b want 0000 0 0",
               bus.gnt, bus.gnt_id, bus.busy);
    end
    bus.req = 4'b0011;
    #2;
    rstn = 1'b1;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL ar_first got gnt=%b id=%0d want 0001 0",
               bus.gnt, bus.gnt_id);
    end
    bus.req = 4'b0000;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_drop_at_limit();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
